// File: rtl/seq_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_timer_pkg
// Brief   : Shared state encoding and width helper for the serial delay timer.
// Revision: 1.0
// ============================================================================
package seq_timer_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } seq_timer_state_t;

    // Counter widths must never collapse to zero bits, even for tiny ranges.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tick_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_tick_divider
// Brief   : Free-running modulo-TICK_CYCLES counter that flags its last cycle.
// Revision: 1.0
// ============================================================================
module seq_tick_divider
    import seq_timer_pkg::*;
#(
    parameter int TICK_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick_last
);

    localparam int               c_tick_w    = clog2_min1(TICK_CYCLES);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_CYCLES - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);

    logic [c_tick_w-1:0] tick_q;
    logic [c_tick_w-1:0] tick_d;

    always_comb begin
        tick_d = tick_q;
        if (clr) begin
            tick_d = '0;
        end else if (en) begin
            tick_d = (tick_q == c_tick_last) ? '0 : tick_q + c_tick_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_last = en && (tick_q == c_tick_last);

endmodule
`default_nettype wire

// File: rtl/seq_delay_timer.sv
`default_nettype none
// ============================================================================
// Module  : seq_delay_timer
// Brief   : Detects a serial start pattern, shifts in a delay, counts
//           (delay+1)*TICK_CYCLES clocks, then holds done until ack.
// Revision: 1.0
// ============================================================================
module seq_delay_timer
    import seq_timer_pkg::*;
#(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] PATTERN     = 4'b1101,
    parameter int                 DELAY_W     = 4,
    parameter int                 TICK_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data_in,
    input  logic               ack,
    output logic               counting,
    output logic               done,
    output logic [DELAY_W-1:0] count
);

    localparam int                  c_valid_w    = clog2_min1(PAT_LEN + 1);
    localparam int                  c_bit_w      = clog2_min1(DELAY_W + 1);
    localparam logic [c_valid_w-1:0] c_valid_full = c_valid_w'(PAT_LEN);
    localparam logic [c_valid_w-1:0] c_valid_need = c_valid_w'(PAT_LEN - 1);
    localparam logic [c_valid_w-1:0] c_valid_one  = c_valid_w'(1);
    localparam logic [c_bit_w-1:0]   c_bit_last   = c_bit_w'(DELAY_W - 1);
    localparam logic [c_bit_w-1:0]   c_bit_one    = c_bit_w'(1);
    localparam logic [DELAY_W-1:0]   c_count_one  = DELAY_W'(1);

    seq_timer_state_t   state_q,   state_d;
    logic [PAT_LEN-1:0] history_q, history_d;
    logic [c_valid_w-1:0] valid_q, valid_d;
    logic [c_bit_w-1:0] bit_cnt_q, bit_cnt_d;
    logic [DELAY_W-1:0] delay_q,   delay_d;
    logic [DELAY_W-1:0] count_q,   count_d;

    logic               w_tick_last;
    logic [PAT_LEN-1:0] w_hist_shift;
    logic [DELAY_W-1:0] w_delay_shift;

    seq_tick_divider #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .clr       (state_q != ST_COUNT),
        .en        (state_q == ST_COUNT),
        .tick_last (w_tick_last)
    );

    // Window of the most recent PAT_LEN bits including the one on data_in now.
    assign w_hist_shift  = PAT_LEN'({history_q, data_in});
    assign w_delay_shift = DELAY_W'({delay_q, data_in});

    always_comb begin
        state_d   = state_q;
        history_d = history_q;
        valid_d   = valid_q;
        bit_cnt_d = bit_cnt_q;
        delay_d   = delay_q;
        count_d   = count_q;
        case (state_q)
            ST_SEARCH: begin
                history_d = w_hist_shift;
                valid_d   = (valid_q == c_valid_full) ? valid_q : valid_q + c_valid_one;
                if ((w_hist_shift == PATTERN) && (valid_q >= c_valid_need)) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    delay_d   = '0;
                end
            end
            ST_SHIFT: begin
                delay_d = w_delay_shift;
                if (bit_cnt_q == c_bit_last) begin
                    state_d   = ST_COUNT;
                    count_d   = w_delay_shift;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + c_bit_one;
                end
            end
            ST_COUNT: begin
                if (w_tick_last) begin
                    if (count_q != '0) begin
                        count_d = count_q - c_count_one;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Fresh search after ack: no stale bits may complete a pattern.
                if (ack) begin
                    state_d   = ST_SEARCH;
                    history_d = '0;
                    valid_d   = '0;
                    count_d   = '0;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SEARCH;
            history_q <= '0;
            valid_q   <= '0;
            bit_cnt_q <= '0;
            delay_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            history_q <= history_d;
            valid_q   <= valid_d;
            bit_cnt_q <= bit_cnt_d;
            delay_q   <= delay_d;
            count_q   <= count_d;
        end
    end

    assign counting = (state_q == ST_COUNT);
    assign done     = (state_q == ST_DONE);
    assign count    = counting ? count_q : '0;

endmodule
`default_nettype wire
